// File: rtl/fp_add_arb_pkg.sv
// fp_add_arb_pkg: shared types and defaults for the two-requester FP adder arbiter.
// Holds the default adder pipeline depth, the fp32 operand pair, the in-flight tag
// (valid + requester id) and the round-robin pointer state encoding.
package fp_add_arb_pkg;

   // Default depth of the shared adder, in edges from add_a/add_b to add_f.
   localparam int LAT_DEF = 4;

   // Width of one IEEE-754 single-precision operand.
   localparam int FP_W = 32;

   // One operand pair as presented by a requester or driven to the adder.
   typedef struct packed {
      logic [FP_W-1:0] a;
      logic [FP_W-1:0] b;
   } fp_pair_t;

   // Tag travelling alongside an op through the adder pipeline.
   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

   // Round-robin pointer: which requester wins when both are valid.
   typedef enum logic {
      PTR_REQ0 = 1'b0,
      PTR_REQ1 = 1'b1
   } ptr_e;

endpackage

// File: rtl/fp_add_arb_rr.sv
// fp_add_arb_rr: two-way round-robin grant with a priority pointer.
// Handshake rule: a requester is accepted on a rising edge where its valid and its
// ready are both high. Ready never depends on anything registered except the pointer,
// and ready only rises for a requester that is already valid, so ready implies handshake.
// The pointer flips to the losing side only when a handshake happens; with en low or
// nothing valid it holds. Reset gates both readies low and returns the pointer to req0.
module fp_add_arb_rr
   import fp_add_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic valid0_i,
   input  logic valid1_i,
   output logic ready0_o,
   output logic ready1_o,
   output logic ptr_o
);

   ptr_e ptr_q;
   ptr_e ptr_d;

   // Pointer state register, cleared to requester 0 by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= PTR_REQ0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Grant decode and next pointer: sole valid wins, ties go to the pointer.
   always_comb begin
      ready0_o = 1'b0;
      ready1_o = 1'b0;
      ptr_d    = ptr_q;
      if (rst && en_i) begin
         if (valid0_i && (!valid1_i || (ptr_q == PTR_REQ0))) begin
            ready0_o = 1'b1;
            ptr_d    = PTR_REQ1;
         end else if (valid1_i) begin
            ready1_o = 1'b1;
            ptr_d    = PTR_REQ0;
         end
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one LAT-deep pipelined fp32 adder between two requesters.
// A granted operand pair is registered onto add_a/add_b; a tag (valid, id) follows it
// down a LAT+1 stage shift register so the result returned on add_f LAT edges later
// can be captured into rsp_f and steered to the right requester's one-cycle strobe.
// Total latency from handshake edge to strobe is LAT+1 edges; one op per cycle.
// arb_ptr exposes the round-robin pointer for observation.
// Optional feature: define FP_ADD_ARB_STATS_EN to add saturating per-requester
// handshake counters grant_cnt0/grant_cnt1 (CNT_W bits each).
module fp_add_arbiter
   import fp_add_arb_pkg::*;
#(
   parameter int LAT   = LAT_DEF
`ifdef FP_ADD_ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_f,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_f,
   output logic        idle,
   output logic        arb_ptr
`ifdef FP_ADD_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
`endif
);

   logic     hs;
   fp_pair_t req0_pair;
   fp_pair_t req1_pair;
   fp_pair_t gnt_pair;
   fp_pair_t ops_q;
   fp_pair_t ops_d;
   tag_t     tag_in;
   tag_t     tag_q [LAT+1];
   tag_t     rsp_tag_q;
   tag_t     rsp_tag_d;
   logic [31:0] rsp_f_q;
   logic [31:0] rsp_f_d;
   logic     busy;

   fp_add_arb_rr u_rr (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en),
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .ready0_o (req0_ready),
      .ready1_o (req1_ready),
      .ptr_o    (arb_ptr)
   );

   assign req0_pair = {req0_a, req0_b};
   assign req1_pair = {req1_a, req1_b};
   assign hs        = req0_ready | req1_ready;
   assign gnt_pair  = req1_ready ? req1_pair : req0_pair;

   // Operand register: load the granted pair on a handshake, otherwise hold.
   always_comb begin
      ops_d = ops_q;
      if (hs) begin
         ops_d = gnt_pair;
      end
   end

   // Operand register state, cleared to zero by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ops_q <= '0;
      end else begin
         ops_q <= ops_d;
      end
   end

   assign add_a = ops_q.a;
   assign add_b = ops_q.b;

   // Tag entering stage 0: the granted requester on a handshake, else a bubble.
   always_comb begin
      tag_in = '0;
      if (hs) begin
         tag_in.valid = 1'b1;
         tag_in.id    = req1_ready;
      end
   end

   // Tag shift register advancing every edge alongside the adder pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i <= LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Response capture: last tag stage lines up with add_f carrying its result.
   always_comb begin
      rsp_tag_d = tag_q[LAT];
      rsp_f_d   = rsp_f_q;
      if (tag_q[LAT].valid) begin
         rsp_f_d = add_f;
      end
   end

   // Response register state; rsp_f holds between strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_tag_q <= '0;
         rsp_f_q   <= '0;
      end else begin
         rsp_tag_q <= rsp_tag_d;
         rsp_f_q   <= rsp_f_d;
      end
   end

   assign rsp0_valid = rsp_tag_q.valid & ~rsp_tag_q.id;
   assign rsp1_valid = rsp_tag_q.valid &  rsp_tag_q.id;
   assign rsp_f      = rsp_f_q;

   // Idle when no tag stage and no response register holds a live op.
   always_comb begin
      busy = rsp_tag_q.valid;
      for (int i = 0; i <= LAT; i++) begin
         busy = busy | tag_q[i].valid;
      end
   end

   assign idle = ~busy;

`ifdef FP_ADD_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt0_d;
   logic [CNT_W-1:0] cnt1_q;
   logic [CNT_W-1:0] cnt1_d;

   // Per-requester handshake counts, sticking at all-ones.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (req0_ready && (cnt0_q != {CNT_W{1'b1}})) begin
         cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (req1_ready && (cnt1_q != {CNT_W{1'b1}})) begin
         cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter state, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed bench for fp_add_arbiter with the adder modelled as an
// LAT-stage delay of add_a ^ add_b. Inputs change 1 time unit after a rising edge;
// outputs are looked at on the falling edge or 1 unit after a rising edge.
module tb_fp_add_arbiter;

  localparam int LAT   = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_f;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_f;
  logic        idle;
  logic        arb_ptr;
`ifdef FP_ADD_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  // expected responses in issue order: {requester id, result}
  logic [32:0] exp_q[$];

  logic [31:0] r0a [4] = '{32'h11110000, 32'h33330000, 32'h55550000, 32'h77770000};
  logic [31:0] r1a [4] = '{32'h22220000, 32'h44440000, 32'h66660000, 32'h88880000};
  logic [32:0] cont_exp [4] = '{33'h0_1111FFFF, 33'h1_4444FFFF, 33'h0_5555FFFF, 33'h1_8888FFFF};

  // clock / reset block
  always #5 clk = ~clk;

  // adder stub: result appears LAT edges after add_a/add_b change
  logic [31:0] stub_q [LAT];
  always @(posedge clk) begin
    stub_q[0] <= add_a ^ add_b;
    for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign add_f = stub_q[LAT-1];

  fp_add_arbiter #(
    .LAT(LAT)
`ifdef FP_ADD_ARB_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_f      (add_f),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_f      (rsp_f),
    .idle       (idle),
    .arb_ptr    (arb_ptr)
`ifdef FP_ADD_ARB_STATS_EN
    , .grant_cnt0 (grant_cnt0)
    , .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every strobe must match the oldest expected response
  always @(negedge clk) begin
    if (rst === 1'b1 && (rsp0_valid || rsp1_valid)) begin
      chk1("rsp_exclusive", rsp0_valid & rsp1_valid, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rsp_unexpected: observed id=%0b f=%08h expected no strobe", rsp1_valid, rsp_f);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk1("rsp_id", rsp1_valid, e[32]);
        chk32("rsp_f", rsp_f, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #2;
    // reset state, with a valid request pending
    req0_valid = 1'b1;
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_rsp0", rsp0_valid, 1'b0);
    chk1("rst_rsp1", rsp1_valid, 1'b0);
    chk32("rst_add_a", add_a, 32'h0);
    chk32("rst_rsp_f", rsp_f, 32'h0);
    chk1("rst_idle", idle, 1'b1);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single op right after release
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    @(negedge clk);
    chk1("single_ready0", req0_ready, 1'b1);
    chk1("single_ready1", req1_ready, 1'b0);
    exp_q.push_back({1'b0, 32'h7F800000});
    tick();
    req0_valid = 1'b0;
    chk32("single_add_a", add_a, 32'h3F800000);
    chk32("single_add_b", add_b, 32'h40000000);
    chk1("single_busy", idle, 1'b0);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk1("single_early", rsp0_valid, 1'b0);
    end
    tick();
    chk1("single_strobe", rsp0_valid, 1'b1);
    chk32("single_rsp_f", rsp_f, 32'h7F800000);
    chk1("single_idle_lo", idle, 1'b0);
    tick();
    chk1("single_strobe_end", rsp0_valid, 1'b0);
    chk1("single_idle_hi", idle, 1'b1);
    chk32("single_hold", rsp_f, 32'h7F800000);

    // operand changes without handshake are ignored
    req0_a = 32'hDEADBEEF; req1_a = 32'hCAFEF00D;
    tick();
    chk32("nohs_add_a", add_a, 32'h3F800000);

    // contention from reset: grants 0,1,0,1
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_a = r0a[i]; req0_b = 32'h0000FFFF;
      req1_valid = 1'b1; req1_a = r1a[i]; req1_b = 32'h0000FFFF;
      @(negedge clk);
      chk1("cont_ready0", req0_ready, (i % 2) == 0);
      chk1("cont_ready1", req1_ready, (i % 2) == 1);
      exp_q.push_back(cont_exp[i]);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk1("cont_rsp0", rsp0_valid, (j % 2) == 0);
      chk1("cont_rsp1", rsp1_valid, (j % 2) == 1);
    end
    tick();

    // throughput: 10 back-to-back req1 ops
    for (int i = 0; i < 15; i++) begin
      req1_valid = (i < 10); req1_a = 32'h00000100 + i; req1_b = 32'hA5A50000;
      if (i < 10) exp_q.push_back({1'b1, 32'hA5A50100 + i});
      @(negedge clk);
      chk1("tput_ready", req1_ready, i < 10);
      tick();
      chk1("tput_rsp", rsp1_valid, i >= 5);
    end
    tick();
    chk1("tput_rsp_end", rsp1_valid, 1'b0);

    // en low freezes grants and the pointer
    req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h00000001;
    exp_q.push_back({1'b0, 32'h40400001});
    tick();
    req0_valid = 1'b0;
    chk1("en_ptr_set", arb_ptr, 1'b1);
    en = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h0;
    req1_valid = 1'b1; req1_a = 32'h0F0F0F0F; req1_b = 32'hF0F0F0F0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("en0_ready0", req0_ready, 1'b0);
      chk1("en0_ready1", req1_ready, 1'b0);
      tick();
      chk1("en0_ptr", arb_ptr, 1'b1);
    end
    en = 1'b1;
    @(negedge clk);
    chk1("en1_ready0", req0_ready, 1'b0);
    chk1("en1_ready1", req1_ready, 1'b1);
    exp_q.push_back({1'b1, 32'hFFFFFFFF});
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk1("en1_ptr", arb_ptr, 1'b0);
    repeat (LAT + 3) tick();

    // reset in the middle of two in-flight ops
    req0_valid = 1'b1; req0_a = 32'h00000001; req0_b = 32'h00000002;
    tick(); tick();
    req0_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk1("mid_rst_idle", idle, 1'b1);
    chk1("mid_rst_rsp0", rsp0_valid, 1'b0);
    chk32("mid_rst_add_a", add_a, 32'h0);
    chk32("mid_rst_add_b", add_b, 32'h0);
    chk32("mid_rst_rsp_f", rsp_f, 32'h0);
    chk1("mid_rst_ptr", arb_ptr, 1'b0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      chk1("post_rst_rsp0", rsp0_valid, 1'b0);
      chk1("post_rst_idle", idle, 1'b1);
    end

`ifdef FP_ADD_ARB_STATS_EN
    // counter saturation: 17 req0 grants on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      req0_valid = 1'b1; req0_a = i; req0_b = 32'h0;
      exp_q.push_back({1'b0, 32'(i)});
      tick();
    end
    req0_valid = 1'b0;
    chk32("stats_cnt0", {{(32-CNT_W){1'b0}}, grant_cnt0}, 32'h0000000F);
    chk32("stats_cnt1", {{(32-CNT_W){1'b0}}, grant_cnt1}, 32'h00000000);
    repeat (LAT + 3) tick();
`endif

    // every expected response must have been seen
    repeat (3) tick();
    chk32("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter: LAT, 4, adder pipeline depth in clock edges from add_a/add_b update to add_f update.
REQ-002 Parameter: CNT_W, 16, width of statistics counters.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  issue enable; low blocks new grants, in-flight ops still complete.
REQ-006 Port: req0_valid, req1_valid  input  1 each  requester operand pair valid.
REQ-007 Port: req0_ready, req1_ready  output  1 each  grant; handshake = valid & ready at a rising edge.
REQ-008 Port: req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single operands.
REQ-009 Port: add_a, add_b  output  32 each  operands driven to the shared pipelined adder.
REQ-010 Port: add_f  input  32  adder result.
REQ-011 Port: rsp0_valid, rsp1_valid  output  1 each  one-cycle result strobe per requester.
REQ-012 Port: rsp_f  output  32  result, qualified by rspN_valid.
REQ-013 Port: idle  output  1  high when no op is in flight.

Function
REQ-014 At most one ready SHALL be high per cycle; readyN is combinational from en, reqN_valid and the priority pointer.
REQ-015 Only one valid: that requester is granted if en=1; both valid: the requester named by the pointer wins.
REQ-016 Pointer SHALL flip to the non-granted requester only on a handshake; no handshake leaves it unchanged.
REQ-017 en=0: both ready SHALL be low; pointer and in-flight state SHALL be unaffected.
REQ-018 On handshake at edge k, add_a/add_b SHALL register the granted operands at edge k; otherwise they hold their value.
REQ-019 A tag shift register of depth LAT+1 (valid bit + requester id) SHALL advance every edge, loaded at stage 0 on handshake, else with an invalid tag.
REQ-020 rsp_f SHALL register add_f and rspN_valid SHALL go high for exactly one cycle after edge k+LAT+1 (total latency LAT+1 edges); rsp_f holds its value when no strobe.
REQ-021 Back-to-back handshakes every cycle SHALL be sustained with no bubbles; responses return in issue order.
REQ-022 rsp0_valid and rsp1_valid SHALL never be high together.
REQ-023 idle SHALL be high iff all tag stages and the response register are invalid.
REQ-024 Requester operand changes without handshake SHALL have no effect.

Reset
REQ-025 rst low SHALL asynchronously clear: ready/rsp valids to 0, add_a/add_b/rsp_f to 0, all tags invalid, pointer to requester 0, idle to 1.
REQ-026 Reset mid-operation SHALL discard in-flight ops; no rsp strobe for them after release.
REQ-027 First edge after release SHALL be able to grant.

Configuration
REQ-028 Macro FP_ADD_ARB_STATS_EN defined: outputs grant_cnt0, grant_cnt1 (CNT_W each) count handshakes per requester, saturating at all-ones, cleared by reset.
REQ-029 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package fp_add_arb_pkg SHALL hold the LAT default, the fp32 operand pair typedef and the tag typedef (valid, id).
REQ-031 Sub-module fp_add_arb_rr SHALL implement the 2-way round-robin grant and pointer; the tag pipe stays in the top.

Verification (adder stubbed as LAT-stage delay of add_a ^ add_b)
REQ-032 Single op: req0 a=0x3F800000 b=0x40000000 -> req0_ready=1 same cycle; rsp0_valid one cycle, LAT+1 edges later, rsp_f=0x7F800000; idle returns to 1.
REQ-033 Contention: both valid continuously for 4 cycles after reset -> grants 0,1,0,1; rsp strobes alternate 0,1,0,1 with matching values.
REQ-034 Throughput: req1 valid for 10 cycles, req0 idle -> 10 consecutive grants, 10 consecutive rsp1 strobes, no gaps.
REQ-035 en=0 with both valid for 3 cycles -> no ready, pointer unchanged; en=1 -> pointer-selected requester granted first.
REQ-036 Reset pulse 2 cycles after 2 grants -> no rsp strobes for them; idle=1, outputs 0 during reset.
REQ-037 With FP_ADD_ARB_STATS_EN and CNT_W=4: 17 req0 grants -> grant_cnt0=0xF, grant_cnt1=0.
